// File: rtl/sram_axi_bridge_pkg.sv
`default_nettype none
// sram_axi_bridge_pkg: FSM encodings, default AXI IDs and size/strobe helpers for the sram-to-AXI bridge.
// Revision: 1.0

package sram_axi_bridge_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_R    = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_B    = 2'd2;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

  // Size 3 never comes from the core; it falls into the full-word case.
  function automatic logic [3:0] sram_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_wr_chan.sv
`default_nettype none
// axi_wr_chan: single-beat AXI write engine; AW and W handshake independently, then B is collected.
// Revision: 1.0

module axi_wr_chan
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  output logic        o_idle,
  output logic [31:0] o_awaddr,
  output logic [2:0]  o_awsize,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  output logic        o_bready,
  input  logic        i_bvalid,
  output logic        o_done
);

  fsm_state_t  r_state;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic        r_done;

  logic w_aw_ok;
  logic w_w_ok;

  assign o_awvalid = (r_state == W_AW) && !r_aw_done;
  assign o_wvalid  = (r_state == W_AW) && !r_w_done;
  assign o_bready  = (r_state == W_B);
  assign o_idle    = (r_state == W_IDLE);
  assign o_awaddr  = r_addr;
  assign o_awsize  = axi_size(r_size);
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_done    = r_done;

  // A channel counts as done once it has handshaken, either earlier or this cycle.
  assign w_aw_ok = r_aw_done || (o_awvalid && i_awready);
  assign w_w_ok  = r_w_done  || (o_wvalid  && i_wready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= W_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_size    <= 2'd0;
      r_wstrb   <= 4'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        W_IDLE: begin
          if (i_start) begin
            r_state   <= W_AW;
            r_addr    <= i_addr;
            r_size    <= i_size;
            r_wdata   <= i_wdata;
            r_wstrb   <= sram_wstrb(i_size, i_addr[1:0]);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        W_AW: begin
          r_aw_done <= w_aw_ok;
          r_w_done  <= w_w_ok;
          if (w_aw_ok && w_w_ok) r_state <= W_B;
        end
        W_B: begin
          if (i_bvalid) begin
            r_state <= W_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= W_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_axi_bridge.sv
`default_nettype none
// sram_axi_bridge: arbitrates the core's inst/data sram-like ports onto one AXI master.
// Revision: 1.0

module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addrok,
  output logic        inst_sram_dataok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addrok,
  output logic        data_sram_dataok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  fsm_state_t  r_rstate;
  logic        r_data_busy;
  logic        r_rd_is_data;
  logic [31:0] r_raddr;
  logic [1:0]  r_rsize;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic        r_inst_dataok;
  logic        r_data_rd_dataok;

  logic w_rd_idle;
  logic w_data_rd_acc;
  logic w_inst_acc;
  logic w_data_wr_acc;
  logic w_wr_idle;
  logic w_wr_done;
  logic w_unused;

  // Accepts are gated by resetn so addrok stays low while reset is held.
  assign w_rd_idle     = resetn && (r_rstate == R_IDLE);
  assign w_data_rd_acc = w_rd_idle && data_sram_req && !data_sram_wr && !r_data_busy;
  assign w_inst_acc    = w_rd_idle && inst_sram_req && !w_data_rd_acc;
  assign w_data_wr_acc = resetn && w_wr_idle && data_sram_req && data_sram_wr && !r_data_busy;

  assign inst_sram_addrok = w_inst_acc;
  assign data_sram_addrok = w_data_rd_acc || w_data_wr_acc;
  assign inst_sram_dataok = r_inst_dataok;
  assign data_sram_dataok = r_data_rd_dataok || w_wr_done;
  assign inst_sram_rdata  = r_inst_rdata;
  assign data_sram_rdata  = r_data_rdata;

  assign arid    = r_rd_is_data ? DATA_ID : INST_ID;
  assign araddr  = r_raddr;
  assign arlen   = 8'd0;
  assign arsize  = axi_size(r_rsize);
  assign arburst = 2'b01;
  assign arvalid = (r_rstate == R_AR);
  assign rready  = (r_rstate == R_R);

  assign awid    = DATA_ID;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign wlast   = 1'b1;

  assign w_unused = ^{inst_sram_wr, inst_sram_wdata, rid, rresp, rlast, bid, bresp};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data_busy <= 1'b0;
    end else if (data_sram_dataok) begin
      r_data_busy <= 1'b0;
    end else if (data_sram_addrok) begin
      r_data_busy <= 1'b1;
    end
  end

  // Response ownership comes from the captured request, not from rid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate         <= R_IDLE;
      r_rd_is_data     <= 1'b0;
      r_raddr          <= 32'd0;
      r_rsize          <= 2'd0;
      r_inst_rdata     <= 32'd0;
      r_data_rdata     <= 32'd0;
      r_inst_dataok    <= 1'b0;
      r_data_rd_dataok <= 1'b0;
    end else begin
      r_inst_dataok    <= 1'b0;
      r_data_rd_dataok <= 1'b0;
      case (r_rstate)
        R_IDLE: begin
          if (w_data_rd_acc || w_inst_acc) begin
            r_rstate     <= R_AR;
            r_rd_is_data <= w_data_rd_acc;
            r_raddr      <= w_data_rd_acc ? data_sram_addr : inst_sram_addr;
            r_rsize      <= w_data_rd_acc ? data_sram_size : inst_sram_size;
          end
        end
        R_AR: begin
          if (arready) r_rstate <= R_R;
        end
        R_R: begin
          if (rvalid) begin
            r_rstate <= R_IDLE;
            if (r_rd_is_data) begin
              r_data_rdata     <= rdata;
              r_data_rd_dataok <= 1'b1;
            end else begin
              r_inst_rdata  <= rdata;
              r_inst_dataok <= 1'b1;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  axi_wr_chan u_axi_wr_chan (
    .clk       (clk),
    .resetn    (resetn),
    .i_start   (w_data_wr_acc),
    .i_addr    (data_sram_addr),
    .i_size    (data_sram_size),
    .i_wdata   (data_sram_wdata),
    .o_idle    (w_wr_idle),
    .o_awaddr  (awaddr),
    .o_awsize  (awsize),
    .o_awvalid (awvalid),
    .i_awready (awready),
    .o_wdata   (wdata),
    .o_wstrb   (wstrb),
    .o_wvalid  (wvalid),
    .i_wready  (wready),
    .o_bready  (bready),
    .i_bvalid  (bvalid),
    .o_done    (w_wr_done)
  );

endmodule

`default_nettype wire

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the CPU core's two sram-like ports (instruction and data) into a single AXI master port toward the SoC interconnect. Sits directly downstream of the `mycpu` core. It arbitrates the inst and data requests, tracks outstanding transactions, derives write strobes, and returns `dataok`/`rdata` in request order per port. At most one read and one write are in flight; one data-port transaction is in flight.

## Interface
- `INST_ID`, 4'd0 — ARID used for instruction reads
- `DATA_ID`, 4'd1 — ARID/AWID used for data accesses
- `clk` in 1 — single clock
- `resetn` in 1 — asynchronous, active-low reset
- `inst_sram_req/wr/size/addr/wdata` in 1/1/2/32/32 — inst request; `wr` is ignored and treated as 0
- `inst_sram_addrok`, `inst_sram_dataok` out 1 — request accepted / read data valid
- `inst_sram_rdata` out 32 — read data
- `data_sram_req/wr/size/addr/wdata` in 1/1/2/32/32 — data request
- `data_sram_addrok`, `data_sram_dataok` out 1; `data_sram_rdata` out 32
- `arid/araddr/arlen/arsize/arburst/arvalid` out 4/32/8/3/2/1; `arready` in 1
- `rid/rdata/rresp/rlast/rvalid` in 4/32/2/1/1; `rready` out 1
- `awid/awaddr/awlen/awsize/awburst/awvalid` out 4/32/8/3/2/1; `awready` in 1
- `wdata/wstrb/wlast/wvalid` out 32/4/1/1; `wready` in 1
- `bid/bresp/bvalid` in 4/2/1; `bready` out 1

## Operation
- Constants: arlen/awlen=0, arburst/awburst=2'b01, wlast=1, arsize/awsize={1'b0,size}.
- Read FSM R_IDLE→R_AR→R_R→R_IDLE. Write FSM W_IDLE→W_AW→W_B→W_IDLE.
- `data_busy` is set when a data request is accepted and cleared when its `dataok` pulses.
- Data read accept (`data_sram_addrok`) requires R_IDLE, data_req, !wr, and !data_busy.
- Inst accept requires R_IDLE, inst_req, and no data read being accepted. Data has priority when both requests arrive in the same cycle.
- Data write accept requires W_IDLE, data_req, wr, and !data_busy.
- `addrok` is combinational from state and req. On accept, the FSM captures addr, size, wdata, and id.
- R_AR: `arvalid`=1 until arready, then R_R.
- R_R: `rready`=1. On rvalid, register rdata and pulse the owning port's `dataok` the next cycle. The owner is selected by the captured id, not by rid. rresp is ignored.
- W_AW: `awvalid` and `wvalid` both assert. Each drops independently after its own handshake. When both are done, move to W_B.
- W_B: `bready`=1. On bvalid, go to W_IDLE and pulse `data_sram_dataok` the next cycle.
- `wstrb` by size:
  - size 0: 4'b0001<<addr[1:0]
  - size 1: addr[1]?4'b1100:4'b0011
  - size 2: 4'b1111
  - size 3 is illegal; the core never issues it.
- `wdata` is passed through unshifted. The core pre-replicates byte and half data.

## Timing
- Reset values:
  - all `*valid` = 0, `rready` = `bready` = 0
  - both `dataok` = 0, both `rdata` = 0
  - FSMs idle, `data_busy` = 0
- `addrok` is 0 in reset because the FSM is in idle with the outputs gated.
- Minimum read latency, with arready and rvalid each answered in one cycle:
  - cycle 0: req and addrok
  - cycle 1: arvalid and arready
  - cycle 2: rvalid
  - cycle 3: dataok
- Minimum write latency: req@0, aw/w handshake@1, bvalid@2, dataok@3.
- A new read may be accepted in the cycle after the rvalid handshake, because the FSM is back in R_IDLE.
- `dataok` is exactly a one-cycle pulse. `rdata` holds its value until the next read completes.
- A read and a write may be outstanding together only if one of them is an inst read. This gives no RAW hazard on data.
- Reset asserted mid-transaction: all state clears immediately. AXI valids drop without a handshake, which is acceptable because the interconnect shares the reset.

## Structure
- Shared package holds:
  - R_*/W_* state encodings
  - INST_ID/DATA_ID defaults
  - the size-to-AXI-size function
  - the wstrb function
- One sub-module, `axi_wr_chan`, holds the write FSM with AW/W/B tracking. The read FSM and arbitration stay in the top.

## Test plan
- Inst read 0xBFC00000, arready=1, rvalid one cycle later with 0x3C08BFAF → araddr=0xBFC00000, arid=0, inst_dataok@3 with rdata 0x3C08BFAF.
- Inst and data reads requested in the same cycle → data addrok=1, inst addrok=0; inst is accepted the cycle after the data rvalid handshake.
- Byte store, size 0, addr 0x...3, wdata 0x44444444 → wstrb=4'b1000, awsize=0, data_dataok one cycle after bvalid.
- awready at cycle 1, wready delayed to cycle 4 → awvalid drops after cycle 1, wvalid held until cycle 4, B accepted afterward.
- Data write followed by a data read → read addrok stays 0 until the write's dataok pulses.
- resetn deasserted while in R_R → arvalid, rready, and dataok are 0 the same cycle; first request after reset behaves normally.
